// File: rtl/cache_mem_responder.sv
// Backing-store RAM responder for the cache miss/write-back path.
// Optional CACHE_MEM_RESPONDER_POSTED_WRITE_EN adds a one-entry posted-write buffer.
module cache_mem_responder #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              accept;
  logic              enter_resp;
  logic              stall;
  logic              post_wr;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              op_rw;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] resp_nxt;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // Words are stored XORed with their address, so a
  // zero-initialised array reads back as mem[a] = a.
  function automatic logic [DATA_W-1:0] addr_key(
    input logic [ADDR_W-1:0] a
  );
    return DATA_W'(a);
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = ~stall;
        accept    = req_valid & ~stall;
        if (accept) begin
          cnt_nxt = WAIT_LD;
          if (LATENCY == 1 || post_wr) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A single-cycle request enters RESP on its accept edge.
  assign op_rw    = (state == IDLE) ? req_rw    : lat_rw;
  assign op_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign op_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  assign rd_data  = fwd_hit ? fwd_data
                            : (mem[op_addr] ^ addr_key(op_addr));
  assign resp_nxt = op_rw ? op_wdata : rd_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_rw    <= req_rw;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (enter_resp) begin
        resp_rdata <= resp_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata ^ addr_key(mem_waddr);
    end
  end

`ifdef CACHE_MEM_RESPONDER_POSTED_WRITE_EN
  logic              pw_valid;
  logic [ADDR_W-1:0] pw_addr;
  logic [DATA_W-1:0] pw_data;
  logic [3:0]        pw_cnt;
  logic              pw_commit;

  assign stall     = pw_valid & req_rw;
  assign post_wr   = req_rw;
  assign pw_commit = pw_valid & (pw_cnt == 4'd1);
  assign fwd_hit   = pw_valid & (pw_addr == op_addr);
  assign fwd_data  = pw_data;
  assign mem_we    = pw_commit;
  assign mem_waddr = pw_addr;
  assign mem_wdata = pw_data;
  assign busy      = (state != IDLE) | pw_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pw_valid <= 1'b0;
      pw_addr  <= '0;
      pw_data  <= '0;
      pw_cnt   <= '0;
    end else if (accept & req_rw) begin
      pw_valid <= 1'b1;
      pw_addr  <= req_addr;
      pw_data  <= req_wdata;
      pw_cnt   <= 4'(LATENCY);
    end else if (pw_valid) begin
      pw_cnt <= pw_cnt - 4'd1;
      if (pw_commit) begin
        pw_valid <= 1'b0;
      end
    end
  end
`else
  assign stall     = 1'b0;
  assign post_wr   = 1'b0;
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
  assign mem_we    = enter_resp & op_rw;
  assign mem_waddr = op_addr;
  assign mem_wdata = op_wdata;
  assign busy      = (state != IDLE);
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: timestamp reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cache_mem_responder;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_rw    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          busy;

  logic          v1 = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic          r1_ready;
  logic          r1_valid;
  logic [DW-1:0] r1_data;
  logic          r1_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) n <= n + 1;

  cache_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .busy(busy)
  );

  cache_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .LATENCY(1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(v1), .req_rw(1'b0),
    .req_addr(a1), .req_wdata(8'h00),
    .req_ready(r1_ready), .resp_valid(r1_valid),
    .resp_rdata(r1_data), .busy(r1_busy)
  );

  // Reference model: memory as "written" overlay on identity content.
  bit            wr_flag [32];
  logic [DW-1:0] wr_val  [32];
  bit            pend    = 1'b0;
  bit            pw_pend = 1'b0;
  int            t_acc   = 0;
  int            lat_cur = LAT;
  int            pw_t    = 0;
  int            acc_t   = 0;
  int            acc_cnt = 0;
  logic          o_rw    = 1'b0;
  logic [AW-1:0] o_addr  = '0;
  logic [AW-1:0] pw_addr = '0;
  logic [DW-1:0] o_wd    = '0;
  logic [DW-1:0] pw_data = '0;
  logic [DW-1:0] exp_rdata = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return wr_flag[a] ? wr_val[a] : DW'(a);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    int e;
    bit new_pw;
    e = n + 1;
    new_pw = 1'b0;
    if (!reset_n) begin
      pend      = 1'b0;
      pw_pend   = 1'b0;
      exp_rdata = '0;
    end else begin
      if (pend && e == t_acc + lat_cur) begin
        pend = 1'b0;
      end else if (!pend && req_valid && !(pw_pend && req_rw)) begin
        pend    = 1'b1;
        t_acc   = e;
        acc_t   = e;
        acc_cnt = acc_cnt + 1;
        o_rw    = req_rw;
        o_addr  = req_addr;
        o_wd    = req_wdata;
        lat_cur = LAT;
`ifdef CACHE_MEM_RESPONDER_POSTED_WRITE_EN
        if (req_rw) begin
          lat_cur = 1;
          new_pw  = 1'b1;
        end
`endif
      end
      if (pend && e == t_acc + lat_cur - 1) begin
        if (o_rw) begin
          exp_rdata = o_wd;
          if (!new_pw) begin
            wr_flag[o_addr] = 1'b1;
            wr_val[o_addr]  = o_wd;
          end
        end else if (pw_pend && pw_addr == o_addr) begin
          exp_rdata = pw_data;
        end else begin
          exp_rdata = ref_rd(o_addr);
        end
      end
      if (pw_pend && e == pw_t + LAT) begin
        wr_flag[pw_addr] = 1'b1;
        wr_val[pw_addr]  = pw_data;
        pw_pend = 1'b0;
      end
      if (new_pw) begin
        pw_pend = 1'b1;
        pw_t    = e;
        pw_addr = o_addr;
        pw_data = o_wd;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h, want %0h", nm, n, got, exp);
    end
  endtask

  always @(negedge clock) begin
    bit ev;
    bit er;
    bit eb;
    if (chk_on) begin
      ev = pend && (n == t_acc + lat_cur - 1);
      er = !pend && !(pw_pend && req_rw);
      eb = pend || pw_pend;
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(eb));
      chk("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    end
  end

  int            pq_t [$];
  logic [DW-1:0] pq_d [$];
  int            p1_t [$];
  logic [DW-1:0] p1_d [$];
  logic          p1_r [$];
  logic          p1_b [$];

  always @(negedge clock) begin
    if (resp_valid) begin
      pq_t.push_back(n);
      pq_d.push_back(resp_rdata);
    end
    if (r1_valid) begin
      p1_t.push_back(n);
      p1_d.push_back(r1_data);
      p1_r.push_back(r1_ready);
      p1_b.push_back(r1_busy);
    end
  end

  task automatic clr();
    pq_t.delete();
    pq_d.delete();
  endtask

  task automatic issue(input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int start;
    int k;
    start = acc_cnt;
    k = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    while (acc_cnt == start && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (acc_cnt == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout addr=%0d: none, want 1", a);
    end
  endtask

  task automatic drop();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((pend || pw_pend) && k < 60) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (pend || pw_pend) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy, want idle");
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int rel;
    int s;
    chk_on = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'h00);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Single read: pulse in the interval after edge T0+2.
    clr();
    issue(1'b0, 5'd20, 8'h00);
    t0 = acc_t;
    drop();
    wait_idle();
    chk("t1_count", 32'(pq_t.size()), 32'd1);
    if (pq_t.size() == 1) begin
      chk("t1_when", 32'(pq_t[0] - t0), 32'd2);
      chk("t1_data", 32'(pq_d[0]), 32'h14);
    end

    // Write then read back, neighbour untouched.
    clr();
    issue(1'b1, 5'd22, 8'hA5);
    drop();
    wait_idle();
    issue(1'b0, 5'd22, 8'h00);
    drop();
    wait_idle();
    issue(1'b0, 5'd21, 8'h00);
    drop();
    wait_idle();
    chk("t2_count", 32'(pq_t.size()), 32'd3);
    if (pq_t.size() == 3) begin
      chk("t2_echo", 32'(pq_d[0]), 32'hA5);
      chk("t2_rd22", 32'(pq_d[1]), 32'hA5);
      chk("t2_rd21", 32'(pq_d[2]), 32'h15);
    end

    // Back-to-back reads with valid held high.
    clr();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, AW'(i), 8'h00);
    end
    drop();
    wait_idle();
    chk("t3_count", 32'(pq_t.size()), 32'd4);
    if (pq_t.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_data", 32'(pq_d[i]), 32'(i));
      end
      for (int i = 1; i < 4; i++) begin
        chk("t3_gap", 32'(pq_t[i] - pq_t[i-1]), 32'd4);
      end
    end

    // Reset one cycle after a write accept aborts it.
    issue(1'b1, 5'd3, 8'hFF);
    drop();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    clr();
    repeat (2) @(posedge clock);
    #1;
    rel = n;
    reset_n = 1'b1;
    issue(1'b0, 5'd3, 8'h00);
    drop();
    wait_idle();
    chk("t4_count", 32'(pq_t.size()), 32'd1);
    if (pq_t.size() == 1) begin
      chk("t4_data", 32'(pq_d[0]), 32'h03);
      chk("t4_when", 32'(pq_t[0] - rel), 32'd3);
    end

    // LATENCY=1 instance: valid held for four edges.
    chk("l1_ready_idle", 32'(r1_ready), 32'd1);
    a1 = 5'd7;
    v1 = 1'b1;
    s  = n;
    repeat (4) @(posedge clock);
    #1;
    v1 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("l1_count", 32'(p1_t.size()), 32'd2);
    if (p1_t.size() == 2) begin
      chk("l1_first", 32'(p1_t[0] - s), 32'd1);
      chk("l1_gap", 32'(p1_t[1] - p1_t[0]), 32'd2);
      chk("l1_data0", 32'(p1_d[0]), 32'h07);
      chk("l1_data1", 32'(p1_d[1]), 32'h07);
      chk("l1_ready_resp", 32'(p1_r[0]), 32'd0);
      chk("l1_busy_resp", 32'(p1_b[0]), 32'd1);
    end

`ifdef CACHE_MEM_RESPONDER_POSTED_WRITE_EN
    // Posted write, stalled second write, reads after commit.
    clr();
    issue(1'b1, 5'd9, 8'h3C);
    t0 = acc_t;
    issue(1'b1, 5'd10, 8'h5A);
    chk("pw_stall", 32'(acc_t - t0), 32'd4);
    issue(1'b0, 5'd9, 8'h00);
    issue(1'b0, 5'd10, 8'h00);
    drop();
    wait_idle();
    chk("pw_count", 32'(pq_t.size()), 32'd4);
    if (pq_t.size() == 4) begin
      chk("pw_w1_lat", 32'(pq_t[0] - t0), 32'd0);
      chk("pw_echo", 32'(pq_d[0]), 32'h3C);
      chk("pw_gap", 32'(pq_t[1] - pq_t[0]), 32'd4);
      chk("pw_rd9", 32'(pq_d[2]), 32'h3C);
      chk("pw_rd10", 32'(pq_d[3]), 32'h5A);
    end
`endif

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Backing-store memory responder for the cache: the RAM end of the cache miss/write-back path.
- Accepts single-beat read or write requests over a valid/ready handshake and services them from a 2^ADDR_W x DATA_W array after a fixed LATENCY.
- Returns a one-cycle response pulse. This replaces the raw RAM instance plus counter, so the cache sees an explicit completion signal.

Parameters:
ADDR_W, 5, address width; memory depth is 2^ADDR_W words.
DATA_W, 8, data word width.
LATENCY, 3, cycles from request accept edge to response pulse; legal range 1..15.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_rw  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  word address.
req_wdata  input  DATA_W  write data; ignored for reads.
req_ready  output  1  responder can accept a request this cycle.
resp_valid  output  1  one-cycle completion pulse; no backpressure.
resp_rdata  output  DATA_W  read data, or echo of write data; held until the next response.
busy  output  1  request in flight (state != IDLE, or posted write pending).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n); clock port is clock.
  - While reset_n = 0: state = IDLE, resp_valid = 0, resp_rdata = 0, busy = 0, req_ready = 1 (after release).
  - Memory contents are NOT reset. Power-up content is mem[a] = a, zero-extended.
- Accept: occurs on a rising edge with req_valid & req_ready. Latch rw, addr and wdata, and load the counter with LATENCY-1.
- FSM:
  - IDLE: req_ready = 1. On accept, go to WAIT; if LATENCY = 1, go directly to RESP.
  - WAIT: req_ready = 0. Decrement the counter each edge. When the counter is 1, the next state is RESP.
  - RESP: req_ready = 0 and resp_valid = 1 for exactly this cycle. Return to IDLE on the next edge.
- Latency and throughput:
  - Accept at edge T0 gives resp_valid high in the cycle after edge T0+LATENCY-1, i.e. LATENCY cycles after accept.
  - Throughput is one request per LATENCY+1 cycles.
- Read: resp_rdata = mem[latched addr], sampled on the edge entering RESP.
- Write: mem[latched addr] is written on the edge entering RESP, and resp_rdata = latched wdata.
  - A read issued after a write's response observes the new value.
- Inputs are ignored when req_ready = 0. req_* changing mid-flight has no effect.
- Widths: all addresses are in range (depth = 2^ADDR_W). The counter is 4 bits.
- Reset mid-operation aborts the request: no response pulse, and an in-flight write is NOT committed.
- Simultaneous reset_n deassert and req_valid: the request is accepted on the first edge after deassert.

Optional Feature:
Macro: CACHE_MEM_RESPONDER_POSTED_WRITE_EN
- Enabled:
  - A write accepted in IDLE is posted into a one-entry buffer (pw_valid, pw_addr, pw_data, pw_cnt = LATENCY).
  - resp_valid pulses in the next cycle (latency 1), and the FSM returns to IDLE.
  - The buffer commits to memory when pw_cnt reaches 0, LATENCY edges after accept; pw_valid then clears.
  - While pw_valid = 1: req_ready = 0 if req_rw = 1, so a second write stalls. Reads are still accepted.
  - A read whose addr matches pw_addr returns pw_data (forwarding). A read completing on the commit edge also returns pw_data.
  - busy includes pw_valid.
  - Reset discards the posted write.
- Disabled: writes follow the normal LATENCY path, and no buffer logic is present.

Test Plan:
- Read after reset, LATENCY = 3: read addr 5'd20 accepted at T0 -> resp_valid pulses 3 cycles later for exactly 1 cycle, resp_rdata = 8'h14; req_ready = 0 until the cycle after the pulse.
- Write then read: write addr 5'd22, data 8'hA5; after its response, read 5'd22 -> resp_rdata = 8'hA5; mem[5'd21] still = 8'h15.
- Back-to-back requests: hold req_valid high with 4 reads (0, 1, 2, 3) -> exactly 4 pulses, 4 cycles apart, data 0, 1, 2, 3; no request dropped or duplicated.
- Reset mid-write: write 5'd3 = 8'hFF, assert reset_n = 0 one cycle after accept -> no resp_valid; after release, read 5'd3 returns 8'h03.
- LATENCY = 1 build: read 5'd7 -> resp_valid in the cycle right after accept, data 8'h07; the next request is accepted 2 cycles after the first.
- POSTED_WRITE_EN: write 5'd9 = 8'h3C, then immediately read 5'd9 -> write resp next cycle; read returns 8'h3C before commit; a second write while pending sees req_ready = 0.
